uart_echo_tester: RTL

Built-in self-test initiator for the UART case-converter path. It generates a printable-ASCII byte stream into the byte interface of uart_tx and receives echoed bytes from the byte interface of uart_rx. Each echo is checked against the upper-cased version of the byte that was sent. The block counts mismatches and timeouts and reports pass/fail, so it acts as the far end of the converter link on a loopback board or in a bench.

---
 rtl/uart_echo_tester.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/uart_echo_tester.sv
// Self-test initiator for the UART case-converter loopback path: streams printable ASCII
// into the transmitter and checks upper-cased echoes returned by the receiver.
module uart_echo_tester #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 50000,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_count,
    input  logic [7:0]       i_seed,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_err_count,
    output logic [CNT_W-1:0] o_sent_count,
    output logic [CNT_W-1:0] o_rcv_count
);
    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned OccW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] sent_q, sent_d;
    logic [CNT_W-1:0] rcv_q, rcv_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [7:0]       cur_q, cur_d;
    logic             timeout_q, timeout_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OccW-1:0]  occ_q, occ_d;
    logic [7:0]       fifo_q [MAX_OUTSTANDING];
    logic [7:0]       fifo_d [MAX_OUTSTANDING];

    logic active, q_empty, q_full, tx_valid, push, rx_take, pop, start_ok, tmo_hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [7:0] to_upper(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    endfunction

    assign active   = (state_q == StRun) || (state_q == StDrain);
    assign q_empty  = (occ_q == '0);
    assign q_full   = (occ_q == OccW'(MAX_OUTSTANDING));
    assign tx_valid = (state_q == StRun) && !q_full && (sent_q < count_q);
    assign push     = tx_valid && i_tx_ready;
    assign rx_take  = active && i_rx_valid;
    assign pop      = rx_take && !q_empty;
    assign start_ok = i_start && ((state_q == StIdle) || (state_q == StDone));

    always_comb begin
        count_d   = count_q;
        sent_d    = sent_q;
        rcv_d     = rcv_q;
        err_d     = err_q;
        cur_d     = cur_q;
        timeout_d = timeout_q;
        tmo_d     = tmo_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        fifo_d    = fifo_q;
        tmo_hit   = 1'b0;
        if (start_ok) begin
            count_d   = i_count;
            cur_d     = (i_seed >= 8'h20 && i_seed <= 8'h7E) ? i_seed : 8'h20;
            sent_d    = '0;
            rcv_d     = '0;
            err_d     = '0;
            timeout_d = 1'b0;
            tmo_d     = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            occ_d     = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = to_upper(cur_q);
                wr_ptr_d         = wr_ptr_q + PtrW'(1);
                cur_d            = (cur_q == 8'h7E) ? 8'h20 : cur_q + 8'h01;
                sent_d           = sat_inc(sent_q);
            end
            // The pop compares against the entry present before this cycle's push.
            if (rx_take) begin
                rcv_d = sat_inc(rcv_q);
                if (q_empty || (i_rx_data != fifo_q[rd_ptr_q])) begin
                    err_d = sat_inc(err_q);
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                occ_d = occ_q + OccW'(1);
            end else if (pop && !push) begin
                occ_d = occ_q - OccW'(1);
            end
            if (!active || i_rx_valid || q_empty) begin
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + TmoW'(1);
            end
            if (active && (tmo_d == TmoW'(TIMEOUT_CYCLES))) begin
                tmo_hit   = 1'b1;
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            sent_q    <= '0;
            rcv_q     <= '0;
            err_q     <= '0;
            cur_q     <= '0;
            timeout_q <= 1'b0;
            tmo_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            fifo_q    <= '{default: '0};
        end else begin
            count_q   <= count_d;
            sent_q    <= sent_d;
            rcv_q     <= rcv_d;
            err_q     <= err_d;
            cur_q     <= cur_d;
            timeout_q <= timeout_d;
            tmo_q     <= tmo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            fifo_q    <= fifo_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (i_start) begin
                    state_d = (i_count == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (tmo_hit) begin
                    state_d = StDone;
                end else if (sent_q == count_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (tmo_hit || q_empty) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        o_busy     = active;
        o_done     = (state_q == StDone);
        o_tx_valid = tx_valid;
        o_pass     = (state_q == StDone) && (err_q == '0) && !timeout_q && (rcv_q == count_q);
    end

    assign o_tx_data    = cur_q;
    assign o_timeout    = timeout_q;
    assign o_err_count  = err_q;
    assign o_sent_count = sent_q;
    assign o_rcv_count  = rcv_q;

endmodule
